// File: rtl/qcl_pkg.sv
// Shared types for the QCL measurement blocks.
// Holds the interval meter FSM state encoding.
package qcl_pkg;

  typedef enum logic [1:0] {
    QCL_IDLE  = 2'd0,
    QCL_COUNT = 2'd1,
    QCL_DONE  = 2'd2
  } qcl_meter_state_e;

endpackage

// File: rtl/qcl_interval_meter.sv
// Measures start_i->stop_i distance in cycles with a saturating timeout; result valid the cycle after stop/timeout.
// Result is held in DONE until yumi_i; starts arriving while a result is pending are dropped and flagged on drop_o.
module qcl_interval_meter
  import qcl_pkg::*;
#(
  parameter  int max_cycles_p = 255,
  localparam int cnt_width_lp = $clog2(max_cycles_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic                    yumi_i,
  output logic                    busy_o,
  output logic                    v_o,
  output logic [cnt_width_lp-1:0] cnt_o,
  output logic                    timeout_o,
  output logic                    drop_o
);

  localparam logic [cnt_width_lp-1:0] max_cnt_lp = cnt_width_lp'(max_cycles_p);
  localparam logic [cnt_width_lp-1:0] one_lp     = cnt_width_lp'(1);

  qcl_meter_state_e        state_q, state_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  logic [cnt_width_lp-1:0] res_cnt_q, res_cnt_d;
  logic                    res_to_q, res_to_d;
  logic                    drop;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_cnt_d = res_cnt_q;
    res_to_d  = res_to_q;
    drop      = 1'b0;

    unique case (state_q)
      QCL_IDLE: begin
        if (start_i) begin
          state_d = QCL_COUNT;
          cnt_d   = one_lp;
        end
      end

      QCL_COUNT: begin
        // Stop beats a coincident start; the start is the one that gets dropped.
        if (stop_i) begin
          state_d   = QCL_DONE;
          res_cnt_d = cnt_q;
          res_to_d  = 1'b0;
          cnt_d     = '0;
          drop      = start_i;
        end else if (start_i) begin
          cnt_d = one_lp;
        end else if (cnt_q == max_cnt_lp) begin
          state_d   = QCL_DONE;
          res_cnt_d = max_cnt_lp;
          res_to_d  = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + one_lp;
        end
      end

      QCL_DONE: begin
        if (yumi_i) begin
          if (start_i) begin
            state_d = QCL_COUNT;
            cnt_d   = one_lp;
          end else begin
            state_d = QCL_IDLE;
          end
        end else begin
          drop = start_i;
        end
      end

      default: begin
        state_d = QCL_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= QCL_IDLE;
      cnt_q     <= '0;
      res_cnt_q <= '0;
      res_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      res_cnt_q <= res_cnt_d;
      res_to_q  <= res_to_d;
    end
  end

  assign busy_o    = (state_q == QCL_COUNT);
  assign v_o       = (state_q == QCL_DONE);
  assign cnt_o     = res_cnt_q;
  assign timeout_o = res_to_q;
  assign drop_o    = drop;

  if (max_cycles_p < 1) begin : g_bad_max
    $fatal(1, "qcl_interval_meter: max_cycles_p must be >= 1");
  end

  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o)
    else $error("qcl_interval_meter: yumi_i asserted while v_o=0");

endmodule

// File: doc/qcl_interval_meter.md
QCL_INTERVAL_METER -- requirements
Module: qcl_interval_meter

Interface
REQ-001 SHALL have parameter max_cycles_p, default 255: largest measurable interval in cycles; must be >= 1.
REQ-002 SHALL derive localparam cnt_width_lp = $clog2(max_cycles_p+1).
REQ-003 clk_i  input  1  sole clock; all state updates on posedge.
REQ-004 reset_n_i  input  1  reset; asynchronous, active-low.
REQ-005 start_i  input  1  single-cycle pulse marking the interval start.
REQ-006 stop_i  input  1  single-cycle pulse marking the interval end.
REQ-007 busy_o  output  1  high while a measurement is in progress (COUNT state).
REQ-008 v_o  output  1  result valid.
REQ-009 cnt_o  output  cnt_width_lp  measured interval in cycles; meaningful only when v_o=1.
REQ-010 timeout_o  output  1  result flag: no stop_i seen within max_cycles_p; meaningful only when v_o=1.
REQ-011 yumi_i  input  1  consumer accepts the result; legal only when v_o=1.
REQ-012 drop_o  output  1  single-cycle pulse: a start_i was discarded.

Function
REQ-013 SHALL implement the FSM states IDLE, COUNT and DONE.
REQ-014 IDLE: start_i -> COUNT, with cnt_r=1 on the next cycle; stop_i is ignored.
REQ-015 COUNT: cnt_r increments by 1 each cycle; with start_i at cycle t and stop_i at cycle t+N, result cnt_o=N.
REQ-016 COUNT: stop_i -> DONE, with cnt_o=cnt_r (value at stop cycle) and timeout_o=0.
REQ-017 COUNT: no stop_i and cnt_r==max_cycles_p -> DONE, with cnt_o=max_cycles_p and timeout_o=1; counter never wraps.
REQ-018 COUNT: start_i without stop_i restarts the measurement (cnt_r=1 next cycle); no drop_o.
REQ-019 COUNT: start_i and stop_i in the same cycle -> stop wins, result captured, start discarded, drop_o=1.
REQ-020 COUNT: stop_i in the same cycle as cnt_r==max_cycles_p -> normal result, timeout_o=0.
REQ-021 DONE: v_o=1; cnt_o and timeout_o held stable until yumi_i.
REQ-022 DONE with yumi_i -> IDLE; DONE with yumi_i and start_i together -> COUNT (cnt_r=1 next cycle), no drop.
REQ-023 DONE: start_i without yumi_i is discarded and pulses drop_o; stop_i is ignored.
REQ-024 IDLE: start_i and stop_i in the same cycle -> start taken, stop ignored.
REQ-025 Result registers (cnt_o, timeout_o) SHALL be registered outputs; v_o, busy_o and drop_o are decoded from registered state (drop_o may be combinational from state and inputs).
REQ-026 Measurement latency: v_o rises the cycle after stop_i or after the timeout cycle.
REQ-027 Simulation-only checks: fatal if max_cycles_p < 1; error if yumi_i is asserted while v_o=0.

Reset
REQ-028 reset_n_i low SHALL asynchronously force state=IDLE, cnt_r=0, cnt_o=0, timeout_o=0.
REQ-029 During reset, outputs SHALL be v_o=0, busy_o=0, drop_o=0.
REQ-030 Reset asserted mid-COUNT or mid-DONE SHALL discard the measurement or result without emitting v_o.
REQ-031 The first start_i SHALL be honoured on the first rising edge after reset_n_i deasserts.

Structure
REQ-032 The FSM state enum (IDLE/COUNT/DONE, 2 bits) SHALL live in shared package qcl_pkg as qcl_meter_state_e.
REQ-033 The block SHALL be a single module with no sub-module; the saturating counter is inline.

Verification (max_cycles_p=8)
REQ-034 start_i@t=2, stop_i@t=6 -> v_o@7, cnt_o=4, timeout_o=0; held 3 cycles until yumi_i@10; v_o=0@11.
REQ-035 start_i@2, no stop -> v_o@11, cnt_o=8, timeout_o=1; stop_i@10 instead -> cnt_o=8, timeout_o=0.
REQ-036 start_i@2, start_i@4, stop_i@7 -> cnt_o=3, drop_o never high; start+stop together@5 in COUNT -> cnt_o=3, drop_o@5.
REQ-037 In DONE: start_i without yumi_i -> drop_o pulse, state stays DONE; start_i with yumi_i -> busy_o next cycle, new result counts from 1.
REQ-038 reset_n_i low for 1 cycle mid-COUNT (cnt_r=5) -> busy_o=0 immediately, no v_o; subsequent start/stop 3 apart -> cnt_o=3.
REQ-039 Chain the existing delay-cycles module (cycles_p=5) start->stop -> cnt_o=5.
